// File: rtl/uart_cmd_decoder.sv
// uart_cmd_decoder: checks each received 8-byte UART frame (header, additive checksum, opcode)
// and turns it into a register-write request or a start/stop pulse; rejected frames are counted.
module uart_cmd_decoder #(
    parameter int         RX_DATA_BYTE_WIDTH = 8,
    parameter logic [7:0] HEADER             = 8'hA5,
    parameter logic [7:0] OP_WRITE           = 8'h01,
    parameter logic [7:0] OP_START           = 8'h02,
    parameter logic [7:0] OP_STOP            = 8'h03
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [RX_DATA_BYTE_WIDTH*8-1:0] rx_data,
    input  logic                            rx_rdy,
    output logic                            rx_ack,
    output logic                            cmd_vld,
    input  logic                            cmd_rdy,
    output logic [7:0]                      cmd_addr,
    output logic [31:0]                     cmd_data,
    output logic                            start_pulse,
    output logic                            stop_pulse,
    output logic                            busy,
    output logic [7:0]                      err_cnt,
    output logic [1:0]                      err_code
);
    localparam int FW = RX_DATA_BYTE_WIDTH * 8;

    typedef enum logic [1:0] {IDLE, SUM, CHECK, CMD} state_e;

    state_e        state_q, state_d;
    logic [FW-1:0] frame_q, frame_d;
    logic [7:0]    sum_q, sum_d;
    logic [2:0]    idx_q, idx_d;
    logic          rx_ack_q, rx_ack_d;
    logic          cmd_vld_q, cmd_vld_d;
    logic [7:0]    cmd_addr_q, cmd_addr_d;
    logic [31:0]   cmd_data_q, cmd_data_d;
    logic          start_q, start_d;
    logic          stop_q, stop_d;
    logic [7:0]    err_cnt_q, err_cnt_d;
    logic [1:0]    err_code_q, err_code_d;
    logic [7:0]    cur_byte, op;
    logic [1:0]    rej;

    // byte idx lives at bit offset 8*(7-idx), and ~idx equals 7-idx for a 3-bit index
    assign cur_byte = frame_q[{~idx_q, 3'b000} +: 8];
    assign op       = frame_q[FW-9 -: 8];
    assign rej      = frame_q[FW-1 -: 8] != HEADER ? 2'b01 :
                      sum_q != frame_q[7:0]        ? 2'b10 :
                      (op != OP_WRITE && op != OP_START && op != OP_STOP) ? 2'b11 : 2'b00;

    always_comb begin
        state_d    = state_q;
        frame_d    = frame_q;
        sum_d      = sum_q;
        idx_d      = idx_q;
        rx_ack_d   = 1'b0;
        cmd_vld_d  = cmd_vld_q;
        cmd_addr_d = cmd_addr_q;
        cmd_data_d = cmd_data_q;
        start_d    = 1'b0;
        stop_d     = 1'b0;
        err_cnt_d  = err_cnt_q;
        err_code_d = err_code_q;
        case (state_q)
            IDLE: if (rx_rdy) begin
                frame_d  = rx_data;
                rx_ack_d = 1'b1;
                sum_d    = 8'd0;
                idx_d    = 3'd0;
                state_d  = SUM;
            end
            SUM: begin
                sum_d   = sum_q + cur_byte;
                idx_d   = idx_q + 3'd1;
                state_d = idx_q == 3'd6 ? CHECK : SUM;
            end
            CHECK: begin
                state_d = IDLE;
                if (rej != 2'b00) begin
                    err_cnt_d  = err_cnt_q == 8'hFF ? err_cnt_q : err_cnt_q + 8'd1;
                    err_code_d = rej;
                end else if (op == OP_WRITE) begin
                    state_d    = CMD;
                    cmd_vld_d  = 1'b1;
                    cmd_addr_d = frame_q[FW-17 -: 8];
                    cmd_data_d = frame_q[FW-25 -: 32];
                end else begin
                    start_d = op == OP_START;
                    stop_d  = op == OP_STOP;
                end
            end
            CMD: if (cmd_rdy) begin
                cmd_vld_d = 1'b0;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            frame_q    <= '0;
            sum_q      <= '0;
            idx_q      <= '0;
            rx_ack_q   <= 1'b0;
            cmd_vld_q  <= 1'b0;
            cmd_addr_q <= '0;
            cmd_data_q <= '0;
            start_q    <= 1'b0;
            stop_q     <= 1'b0;
            err_cnt_q  <= '0;
            err_code_q <= '0;
        end else begin
            state_q    <= state_d;
            frame_q    <= frame_d;
            sum_q      <= sum_d;
            idx_q      <= idx_d;
            rx_ack_q   <= rx_ack_d;
            cmd_vld_q  <= cmd_vld_d;
            cmd_addr_q <= cmd_addr_d;
            cmd_data_q <= cmd_data_d;
            start_q    <= start_d;
            stop_q     <= stop_d;
            err_cnt_q  <= err_cnt_d;
            err_code_q <= err_code_d;
        end
    end

    assign rx_ack      = rx_ack_q;
    assign cmd_vld     = cmd_vld_q;
    assign cmd_addr    = cmd_addr_q;
    assign cmd_data    = cmd_data_q;
    assign start_pulse = start_q;
    assign stop_pulse  = stop_q;
    assign busy        = state_q != IDLE;
    assign err_cnt     = err_cnt_q;
    assign err_code    = err_code_q;
endmodule

// File: tb/tb_uart_cmd_decoder.sv
// tb_uart_cmd_decoder: frame driver pushes the reference model's verdict into a scoreboard;
// a monitor pops it whenever the decoder presents a decision.
module tb_uart_cmd_decoder;
    localparam int K_WRITE = 0, K_START = 1, K_STOP = 2, K_REJ = 3;

    typedef struct {
        int          kind;
        logic [7:0]  addr;
        logic [31:0] data;
        logic [7:0]  cnt;
        logic [1:0]  code;
    } exp_t;

    logic        clk = 0, rst = 1, rx_rdy = 0, cmd_rdy = 0;
    logic [63:0] rx_data = '0;
    logic        rx_ack, cmd_vld, start_pulse, stop_pulse, busy;
    logic [7:0]  cmd_addr, err_cnt;
    logic [31:0] cmd_data;
    logic [1:0]  err_code;

    uart_cmd_decoder dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_rdy(rx_rdy), .rx_ack(rx_ack),
        .cmd_vld(cmd_vld), .cmd_rdy(cmd_rdy), .cmd_addr(cmd_addr), .cmd_data(cmd_data),
        .start_pulse(start_pulse), .stop_pulse(stop_pulse), .busy(busy),
        .err_cnt(err_cnt), .err_code(err_code)
    );

    always #5 clk = ~clk;

    exp_t exp_q[$];
    int   ack_cyc[$];
    int   n_chk = 0, n_pass = 0, n_sent = 0, n_acks = 0, cyc = 0;
    int   rdy_delay = 0;
    logic rdy_pre = 0;
    int   m_cnt = 0;
    logic [1:0] m_code = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    endtask

    // Reference: decide the frame's fate straight from the byte list.
    function automatic exp_t model(input logic [63:0] f);
        exp_t       e;
        logic [7:0] b [8];
        int         s = 0;
        int         r;
        for (int i = 0; i < 8; i++) b[i] = f[63-8*i -: 8];
        for (int i = 0; i < 7; i++) s += int'(b[i]);
        r = b[0] != 8'hA5 ? 1 : (s % 256) != int'(b[7]) ? 2 : (b[1] < 8'd1 || b[1] > 8'd3) ? 3 : 0;
        e.addr = b[2];
        e.data = {b[3], b[4], b[5], b[6]};
        if (r != 0) begin
            m_cnt  = m_cnt < 255 ? m_cnt + 1 : 255;
            m_code = 2'(r);
            e.kind = K_REJ;
        end else e.kind = b[1] == 8'd1 ? K_WRITE : b[1] == 8'd2 ? K_START : K_STOP;
        e.cnt  = 8'(m_cnt);
        e.code = m_code;
        return e;
    endfunction

    function automatic logic [63:0] mk(input logic [7:0] hdr, input logic [7:0] op,
                                       input logic [7:0] addr, input logic [31:0] data,
                                       input logic [7:0] adj);
        logic [55:0] body;
        logic [7:0]  s;
        body = {hdr, op, addr, data};
        s = 8'd0;
        for (int i = 0; i < 7; i++) s += body[8*i +: 8];
        return {body, s + adj};
    endfunction

    task automatic send(input logic [63:0] f);
        logic got;
        @(negedge clk);
        rx_data = f;
        rx_rdy  = 1;
        exp_q.push_back(model(f));
        n_sent++;
        got = 0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(posedge clk); #1;
            got = rx_ack;
        end
        chk("ack_seen", got, 1);
        @(negedge clk);
        rx_rdy = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1;
        @(posedge clk); #1;
        chk("rst_outputs", {rx_ack, cmd_vld, cmd_addr, cmd_data, start_pulse, stop_pulse, busy, err_cnt, err_code}, 0);
        exp_q.delete();
        m_cnt  = 0;
        m_code = 0;
        @(negedge clk);
        rst = 0;
    endtask

    task automatic drain();
        for (int i = 0; i < 300 && (exp_q.size() != 0 || busy); i++) @(posedge clk);
        #1;
        chk("drained", exp_q.size(), 0);
    endtask

    // Register-file side: ready goes high rdy_delay cycles after the request appears.
    initial begin
        int vcnt = 0;
        forever begin
            @(negedge clk);
            if (!cmd_vld) begin
                cmd_rdy = rdy_pre;
                vcnt    = 0;
            end else begin
                cmd_rdy = vcnt >= rdy_delay;
                vcnt++;
            end
        end
    end

    // Monitor: decision is either cmd_vld rising or busy falling from a non-CMD state.
    initial begin
        logic p_ack = 0, p_vld = 0, p_busy = 0, p_start = 0, p_stop = 0;
        logic [7:0]  p_addr = 0;
        logic [31:0] p_data = 0;
        exp_t e;
        int   kind, a;
        forever begin
            @(posedge clk); #1;
            cyc++;
            if (rst) begin
                ack_cyc.delete();
                {p_ack, p_vld, p_busy, p_start, p_stop} = '0;
                continue;
            end
            if (rx_ack) begin
                n_acks++;
                ack_cyc.push_back(cyc);
            end
            if (p_ack) chk("ack_one_cycle", rx_ack, 0);
            if (p_start) chk("start_one_cycle", start_pulse, 0);
            if (p_stop) chk("stop_one_cycle", stop_pulse, 0);
            if (p_vld) begin
                chk("vld_handshake", cmd_vld, !cmd_rdy);
                if (cmd_vld) chk("cmd_stable", {cmd_addr, cmd_data}, {p_addr, p_data});
            end
            if ((cmd_vld && !p_vld) || (p_busy && !busy && !p_vld)) begin
                kind = (cmd_vld && !p_vld) ? K_WRITE : start_pulse ? K_START : stop_pulse ? K_STOP : K_REJ;
                chk("sb_has_entry", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("kind", kind, e.kind);
                    chk("err_cnt", err_cnt, e.cnt);
                    chk("err_code", err_code, e.code);
                    if (e.kind == K_WRITE) chk("cmd_fields", {cmd_addr, cmd_data}, {e.addr, e.data});
                    if (ack_cyc.size() > 0) begin
                        a = ack_cyc.pop_front();
                        chk("latency", cyc - a, 8);
                    end
                end
            end else chk("no_stray_pulse", {start_pulse, stop_pulse}, 0);
            {p_ack, p_vld, p_busy, p_start, p_stop} = {rx_ack, cmd_vld, busy, start_pulse, stop_pulse};
            p_addr = cmd_addr;
            p_data = cmd_data;
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int k;
        logic [7:0] op;
        repeat (3) @(posedge clk);
        do_reset();
        rdy_delay = 3;
        send(64'hA501_10DE_ADBE_EFEE);
        drain();
        chk("write_err_cnt", err_cnt, 0);
        rdy_delay = 0;
        send(64'hA502_0000_0000_00A7);
        send(64'hA503_0000_0000_00A8);
        send(64'hA501_10DE_ADBE_EFEF);
        send(64'h5A01_10DE_ADBE_EFEE);
        send(64'hA507_0000_0000_00AC);
        drain();
        chk("rejects_cnt", err_cnt, 3);
        chk("rejects_code", err_code, 2'b11);
        for (int i = 0; i < 260; i++) send(mk(8'hA5, 8'h01, 8'(i), 32'(i * 7), 8'd1));
        drain();
        chk("sat_cnt", err_cnt, 255);
        chk("sat_code", err_code, 2'b10);
        // reset while summing, then a normal write
        send(64'hA501_10DE_ADBE_EFEE);
        repeat (2) @(posedge clk);
        do_reset();
        send(64'hA502_0000_0000_00A7);
        // reset while holding a write request
        rdy_delay = 1000;
        send(64'hA501_10DE_ADBE_EFEE);
        for (int i = 0; i < 30 && !cmd_vld; i++) @(posedge clk);
        #1;
        chk("cmd_pending", cmd_vld, 1);
        do_reset();
        rdy_delay = 2;
        send(64'hA501_10DE_ADBE_EFEE);
        drain();
        for (int i = 0; i < 200; i++) begin
            k = $urandom_range(0, 5);
            rdy_delay = $urandom_range(0, 4);
            rdy_pre   = 1'($urandom_range(0, 1));
            op = k == 5 ? ($urandom_range(0, 1) ? 8'd0 : 8'($urandom_range(4, 255))) : k == 0 ? 8'd1 : k == 1 ? 8'd2 : 8'd3;
            send(mk(k == 3 ? 8'hA5 ^ 8'($urandom_range(1, 255)) : 8'hA5, op, 8'($urandom), 32'($urandom),
                    k == 4 ? 8'($urandom_range(1, 255)) : 8'd0));
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end
        drain();
        chk("ack_count", n_acks, n_sent);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
